// File: rtl/pong_game_ctl.sv
// rtl/pong_game_ctl.sv - PONG play-state sequencer, ball motion and scoring
//
// Updates game state once per frame, on the cycle after vblnk_in rises, so
// the drawing pipeline sees constant coordinates for a whole frame.
//
// Ports:
//   pclk                  pixel clock, all logic on the rising edge
//   rst                   asynchronous active-low reset
//   vblnk_in              vertical blank from the timing path
//   start                 start / restart request (IDLE and OVER only)
//   paddle_l_y/paddle_r_y paddle top y, sampled on the frame-tick cycle
//   ball_x/ball_y         ball top-left corner
//   score_l/score_r       player scores
//   state                 IDLE=0 SERVE=1 PLAY=2 SCORE=3 OVER=4
//   frame_tick            one-cycle pulse, one cycle after vblnk_in rises
//   ball_visible          high in SERVE and PLAY
//
// Build option SPEEDUP_EN: horizontal step grows by one every four paddle
// hits (capped at SPEED+3) and returns to SPEED on every serve.

module pong_game_ctl #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 80,
    parameter int PADDLE_L_X   = 20,
    parameter int PADDLE_R_X   = 770,
    parameter int SPEED        = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int SCORE_FRAMES = 30,
    parameter int WIN_SCORE    = 9
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [2:0]  state,
    output logic        frame_tick,
    output logic        ball_visible
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_SCORE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [10:0] BALL_X0    = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y0    = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_X_MAX = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] BALL_Y_MAX = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] BALL_X_LH  = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] BALL_X_RH  = 11'(PADDLE_R_X - BALL_SIZE);

    // All geometry compares are done 12 bits wide so sums never wrap.
    localparam logic [11:0] W12    = 12'(SCREEN_W);
    localparam logic [11:0] H12    = 12'(SCREEN_H);
    localparam logic [11:0] BS12   = 12'(BALL_SIZE);
    localparam logic [11:0] PH12   = 12'(PADDLE_H);
    localparam logic [11:0] L_EDGE = 12'(PADDLE_L_X + PADDLE_W);
    localparam logic [11:0] R_EDGE = 12'(PADDLE_R_X);
    localparam logic [11:0] SPD12  = 12'(SPEED);

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] SCORE_LAST = 8'(SCORE_FRAMES - 1);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [10:0] ball_x_q, ball_x_d;
    logic [10:0] ball_y_q, ball_y_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic        dir_x_q, dir_x_d;          // 1 = moving right
    logic        dir_y_q, dir_y_d;          // 1 = moving down
    logic        serve_right_q, serve_right_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        vblnk_d_q;
    logic        frame_tick_q;
    logic        ball_visible_q, ball_visible_d;

    logic [11:0] step12;
`ifdef SPEEDUP_EN
    localparam logic [11:0] STEP_MAX = 12'(SPEED + 3);
    logic [11:0] step_q, step_d;
    logic [2:0]  hits_q, hits_d;
    assign step12 = step_q;
`else
    assign step12 = SPD12;
`endif

    logic [11:0] x12, y12, pl12, pr12;
    logic [11:0] nx_l, nx_r;
    logic        overlap_l, overlap_r;

    assign x12  = {1'b0, ball_x_q};
    assign y12  = {1'b0, ball_y_q};
    assign pl12 = {1'b0, paddle_l_y};
    assign pr12 = {1'b0, paddle_r_y};
    assign nx_l = x12 - step12;
    assign nx_r = x12 + step12;

    assign overlap_l = (y12 + BS12 > pl12) && (y12 < pl12 + PH12);
    assign overlap_r = (y12 + BS12 > pr12) && (y12 < pr12 + PH12);

    always_comb begin
        state_d       = state_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        serve_right_d = serve_right_q;
        cnt_d         = cnt_q;
`ifdef SPEEDUP_EN
        step_d        = step_q;
        hits_d        = hits_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ball_x_d      = BALL_X0;
                ball_y_d      = BALL_Y0;
                score_l_d     = 4'd0;
                score_r_d     = 4'd0;
                dir_x_d       = 1'b1;
                dir_y_d       = 1'b1;
                serve_right_d = 1'b1;
                if (start) begin
                    state_d = ST_SERVE;
                    cnt_d   = 8'd0;
                end
            end

            ST_SERVE: begin
                ball_x_d = BALL_X0;
                ball_y_d = BALL_Y0;
                dir_x_d  = serve_right_q;
                dir_y_d  = 1'b1;
`ifdef SPEEDUP_EN
                step_d   = SPD12;
                hits_d   = 3'd0;
`endif
                if (frame_tick_q) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (frame_tick_q) begin
                    // Vertical: clamp to the wall and reverse on contact.
                    if (dir_y_q) begin
                        if (y12 + BS12 + SPD12 > H12) begin
                            ball_y_d = BALL_Y_MAX;
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = ball_y_q + 11'(SPEED);
                        end
                    end else begin
                        if (y12 < SPD12) begin
                            ball_y_d = 11'd0;
                            dir_y_d  = 1'b1;
                        end else begin
                            ball_y_d = ball_y_q - 11'(SPEED);
                        end
                    end

                    // Horizontal: paddle hit only when the step crosses the
                    // paddle face from the play-field side.
                    if (!dir_x_q) begin
                        if (nx_l <= L_EDGE && x12 >= L_EDGE && overlap_l) begin
                            ball_x_d = BALL_X_LH;
                            dir_x_d  = 1'b1;
`ifdef SPEEDUP_EN
                            hits_d = hits_q + 3'd1;
                            if (hits_q[1:0] == 2'b11 && step_q < STEP_MAX)
                                step_d = step_q + 12'd1;
`endif
                        end else if (x12 < step12) begin
                            ball_x_d      = 11'd0;
                            score_r_d     = score_r_q + 4'd1;
                            serve_right_d = 1'b0;
                            state_d       = ST_SCORE;
                            cnt_d         = 8'd0;
                        end else begin
                            ball_x_d = nx_l[10:0];
                        end
                    end else begin
                        if (nx_r + BS12 >= R_EDGE && x12 + BS12 <= R_EDGE && overlap_r) begin
                            ball_x_d = BALL_X_RH;
                            dir_x_d  = 1'b0;
`ifdef SPEEDUP_EN
                            hits_d = hits_q + 3'd1;
                            if (hits_q[1:0] == 2'b11 && step_q < STEP_MAX)
                                step_d = step_q + 12'd1;
`endif
                        end else if (x12 + BS12 + step12 > W12) begin
                            ball_x_d      = BALL_X_MAX;
                            score_l_d     = score_l_q + 4'd1;
                            serve_right_d = 1'b1;
                            state_d       = ST_SCORE;
                            cnt_d         = 8'd0;
                        end else begin
                            ball_x_d = nx_r[10:0];
                        end
                    end
                end
            end

            ST_SCORE: begin
                if (frame_tick_q) begin
                    if (cnt_q == SCORE_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_OVER: begin
                if (start)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        ball_visible_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ball_x_q       <= BALL_X0;
            ball_y_q       <= BALL_Y0;
            score_l_q      <= 4'd0;
            score_r_q      <= 4'd0;
            dir_x_q        <= 1'b1;
            dir_y_q        <= 1'b1;
            serve_right_q  <= 1'b1;
            cnt_q          <= 8'd0;
            vblnk_d_q      <= 1'b0;
            frame_tick_q   <= 1'b0;
            ball_visible_q <= 1'b0;
`ifdef SPEEDUP_EN
            step_q         <= SPD12;
            hits_q         <= 3'd0;
`endif
        end else begin
            state_q        <= state_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            serve_right_q  <= serve_right_d;
            cnt_q          <= cnt_d;
            vblnk_d_q      <= vblnk_in;
            frame_tick_q   <= vblnk_in & ~vblnk_d_q;
            ball_visible_q <= ball_visible_d;
`ifdef SPEEDUP_EN
            step_q         <= step_d;
            hits_q         <= hits_d;
`endif
        end
    end

    assign ball_x       = ball_x_q;
    assign ball_y       = ball_y_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign state        = state_q;
    assign frame_tick   = frame_tick_q;
    assign ball_visible = ball_visible_q;

endmodule

// File: tb/tb_pong_game_ctl.sv
// tb/tb_pong_game_ctl.sv - directed bench for pong_game_ctl

module tb_pong_game_ctl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk_in = 1'b0;
    logic        start = 1'b0;
    logic [10:0] paddle_l_y = 11'd0;
    logic [10:0] paddle_r_y = 11'd0;
    logic [10:0] ball_x;
    logic [10:0] ball_y;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic [2:0]  state;
    logic        frame_tick;
    logic        ball_visible;

    int total = 0;
    int bad = 0;

    pong_game_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .vblnk_in     (vblnk_in),
        .start        (start),
        .paddle_l_y   (paddle_l_y),
        .paddle_r_y   (paddle_r_y),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score_l      (score_l),
        .score_r      (score_r),
        .state        (state),
        .frame_tick   (frame_tick),
        .ball_visible (ball_visible)
    );

    always #5 pclk = ~pclk;

    // One frame: vblnk high two cycles, low two cycles; returns #1 after an edge.
    task automatic frame();
        vblnk_in = 1'b1;
        repeat (2) @(posedge pclk);
        #1 vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge pclk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #3;
        total++; if (ball_x !== 11'd395) begin bad++; $display("FAIL reset_ball_x got %0d want 395", ball_x); end
        total++; if (ball_y !== 11'd295) begin bad++; $display("FAIL reset_ball_y got %0d want 295", ball_y); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", state); end
        total++; if ({score_l, score_r} !== 8'h00) begin bad++; $display("FAIL reset_scores got %0d/%0d want 0/0", score_l, score_r); end
        total++; if ({frame_tick, ball_visible} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b%b want 00", frame_tick, ball_visible); end
        @(posedge pclk);
        #1 rst = 1'b1;
    endtask

    task automatic test_frame_tick();
        int pulses;
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL tick_early got %b want 0", frame_tick); end
        @(posedge pclk);
        #1;
        total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL tick_pulse got %b want 1", frame_tick); end
        pulses = 0;
        for (int i = 0; i < 27; i++) begin
            @(posedge pclk);
            #1;
            if (frame_tick === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL tick_extra got %0d want 0", pulses); end
        vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
    endtask

    task automatic test_serve_play();
        paddle_r_y = 11'd480;
        paddle_l_y = 11'd0;
        pulse_start();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL serve_enter got %0d want 1", state); end
        total++; if (ball_visible !== 1'b1) begin bad++; $display("FAIL serve_visible got %b want 1", ball_visible); end
        for (int i = 0; i < 59; i++) frame();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL serve_59 got %0d want 1", state); end
        frame();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL serve_60 got %0d want 2", state); end
        total++; if ({ball_x, ball_y} !== {11'd395, 11'd295}) begin bad++; $display("FAIL play_entry got %0d,%0d want 395,295", ball_x, ball_y); end
        frame();
        total++; if ({ball_x, ball_y} !== {11'd399, 11'd299}) begin bad++; $display("FAIL play_tick1 got %0d,%0d want 399,299", ball_x, ball_y); end
    endtask

    // Continues the rally from play tick 2: bottom wall at tick 74, right
    // paddle hit at tick 92, top wall at tick 222.
    task automatic test_bounces();
        for (int k = 2; k <= 223; k++) begin
            frame();
            if (k == 73) begin
                total++; if (ball_y !== 11'd587) begin bad++; $display("FAIL y_t73 got %0d want 587", ball_y); end
            end
            if (k == 74) begin
                total++; if (ball_y !== 11'd590) begin bad++; $display("FAIL y_bottom got %0d want 590", ball_y); end
            end
            if (k == 91) begin
                total++; if ({ball_x, ball_y} !== {11'd759, 11'd522}) begin bad++; $display("FAIL pos_t91 got %0d,%0d want 759,522", ball_x, ball_y); end
            end
            if (k == 92) begin
                total++; if ({ball_x, ball_y} !== {11'd760, 11'd518}) begin bad++; $display("FAIL r_hit got %0d,%0d want 760,518", ball_x, ball_y); end
            end
            if (k == 93) begin
                total++; if ({ball_x, ball_y} !== {11'd756, 11'd514}) begin bad++; $display("FAIL r_hit_dir got %0d,%0d want 756,514", ball_x, ball_y); end
            end
            if (k == 221) begin
                total++; if ({ball_x, ball_y} !== {11'd244, 11'd2}) begin bad++; $display("FAIL pos_t221 got %0d,%0d want 244,2", ball_x, ball_y); end
            end
            if (k == 222) begin
                total++; if (ball_y !== 11'd0) begin bad++; $display("FAIL y_top got %0d want 0", ball_y); end
            end
            if (k == 223) begin
                total++; if ({ball_x, ball_y} !== {11'd236, 11'd4}) begin bad++; $display("FAIL y_top_dir got %0d,%0d want 236,4", ball_x, ball_y); end
            end
        end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL still_play got %0d want 2", state); end
    endtask

    task automatic test_reset_mid_play();
        @(posedge pclk);
        #1 vblnk_in = 1'b1;
        @(posedge pclk);
        #1 rst = 1'b0;
        #1;
        total++; if ({ball_x, ball_y} !== {11'd395, 11'd295}) begin bad++; $display("FAIL rst_mid_ball got %0d,%0d want 395,295", ball_x, ball_y); end
        total++; if ({state, score_l, score_r} !== 11'd0) begin bad++; $display("FAIL rst_mid_state got %0d %0d/%0d want 0 0/0", state, score_l, score_r); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_tick got %b want 0", frame_tick); end
        vblnk_in = 1'b0;
        @(posedge pclk);
        #1 rst = 1'b1;
    endtask

    // Right paddle parked at the top: every serve goes right and is missed,
    // so the left player scores each rally until the game ends.
    task automatic test_left_wins();
        paddle_r_y = 11'd0;
        paddle_l_y = 11'd0;
        pulse_start();
        for (int r = 1; r <= 9; r++) begin
            for (int i = 0; i < 60; i++) frame();
            total++; if (state !== 3'd2) begin bad++; $display("FAIL rally%0d_play got %0d want 2", r, state); end
            if (r == 1) begin
                for (int i = 0; i < 50; i++) frame();
                start = 1'b1;
                frame();
                start = 1'b0;
                total++; if (state !== 3'd2) begin bad++; $display("FAIL start_in_play got %0d want 2", state); end
                for (int i = 0; i < 48; i++) frame();
            end else begin
                for (int i = 0; i < 99; i++) frame();
            end
            total++; if ({state, ball_x} !== {3'd3, 11'd790}) begin bad++; $display("FAIL rally%0d_miss got %0d,%0d want 3,790", r, state, ball_x); end
            total++; if ({score_l, score_r} !== {4'(r), 4'd0}) begin bad++; $display("FAIL rally%0d_score got %0d/%0d want %0d/0", r, score_l, score_r, r); end
            total++; if (ball_visible !== 1'b0) begin bad++; $display("FAIL rally%0d_vis got %b want 0", r, ball_visible); end
            for (int i = 0; i < 29; i++) frame();
            if (r == 1) begin
                total++; if ({state, ball_x} !== {3'd3, 11'd790}) begin bad++; $display("FAIL score_hold got %0d,%0d want 3,790", state, ball_x); end
            end
            frame();
            if (r < 9) begin
                total++; if (state !== 3'd1) begin bad++; $display("FAIL rally%0d_serve got %0d want 1", r, state); end
            end else begin
                total++; if ({state, score_l} !== {3'd4, 4'd9}) begin bad++; $display("FAIL game_over got %0d,%0d want 4,9", state, score_l); end
            end
        end
        frame();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL over_hold got %0d want 4", state); end
        pulse_start();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL over_to_idle got %0d want 0", state); end
        @(posedge pclk);
        #1;
        total++; if ({score_l, score_r} !== 8'h00) begin bad++; $display("FAIL idle_clear got %0d/%0d want 0/0", score_l, score_r); end
        total++; if ({ball_x, ball_y} !== {11'd395, 11'd295}) begin bad++; $display("FAIL idle_ball got %0d,%0d want 395,295", ball_x, ball_y); end
    endtask

    initial begin
        test_reset();
        test_frame_tick();
        test_serve_play();
        test_bounces();
        test_reset_mid_play();
        test_left_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctl.md
Name: pong_game_ctl

Overview:
Frame-synchronous game controller that sequences the PONG play state and drives ball position and scores into the drawing pipeline. It sits beside the timing/background/draw chain, samples vblnk_in from the timing path, and updates game state once per frame during vertical blanking, so drawing stages always see stable coordinates for a whole frame.

Parameters:
SCREEN_W, 800, active width in pixels
SCREEN_H, 600, active height in pixels
BALL_SIZE, 10, ball square side in pixels
PADDLE_W, 10, paddle width
PADDLE_H, 80, paddle height
PADDLE_L_X, 20, left paddle left edge x
PADDLE_R_X, 770, right paddle left edge x
SPEED, 4, ball step per frame in x and in y
SERVE_FRAMES, 60, frames held in SERVE
SCORE_FRAMES, 30, frames held in SCORE
WIN_SCORE, 9, score that ends the game

Ports:
pclk  in  1  pixel clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
vblnk_in  in  1  vertical blank from timing path
start  in  1  level/pulse start request, sampled every cycle
paddle_l_y  in  11  left paddle top y
paddle_r_y  in  11  right paddle top y
ball_x  out  11  ball top-left x
ball_y  out  11  ball top-left y
score_l  out  4  left score
score_r  out  4  right score
state  out  3  IDLE=0 SERVE=1 PLAY=2 SCORE=3 OVER=4
frame_tick  out  1  one-cycle pulse on vblnk_in rising edge
ball_visible  out  1  1 in SERVE and PLAY only

Behaviour:
- Reset (rst=0, async): state=IDLE, ball_x=(SCREEN_W-BALL_SIZE)/2=395, ball_y=(SCREEN_H-BALL_SIZE)/2=295, scores 0, dir_x=right, dir_y=down, frame counter 0, frame_tick=0, vblnk delay reg 0. Reset mid-game aborts immediately, no partial update.
- frame_tick: vblnk_d registered each cycle; frame_tick registered = vblnk_in & ~vblnk_d (1-cycle latency after rising edge). All position/counter updates occur only on cycles with frame_tick=1.
- IDLE: ball centred, scores 0; start=1 -> SERVE (any cycle, counter cleared).
- SERVE: ball centred; counter++ per tick; at SERVE_FRAMES ticks -> PLAY. dir_x toward side that conceded last point (right after reset), dir_y=down.
- PLAY, per tick, vertical: up and ball_y<SPEED -> ball_y=0, dir down; down and ball_y+BALL_SIZE+SPEED>SCREEN_H -> ball_y=SCREEN_H-BALL_SIZE, dir up; else ball_y±SPEED.
- PLAY, horizontal left: next x = ball_x-SPEED. If next x <= PADDLE_L_X+PADDLE_W and ball_x >= PADDLE_L_X+PADDLE_W and overlap (ball_y+BALL_SIZE>paddle_l_y and ball_y<paddle_l_y+PADDLE_H) -> ball_x=PADDLE_L_X+PADDLE_W, dir right. Else if ball_x<SPEED -> ball_x=0, score_r++, -> SCORE. Else ball_x=next.
- Right symmetric: next=ball_x+SPEED; hit when next+BALL_SIZE >= PADDLE_R_X, ball_x+BALL_SIZE <= PADDLE_R_X and overlap with paddle_r_y -> ball_x=PADDLE_R_X-BALL_SIZE, dir left; miss when ball_x+BALL_SIZE+SPEED>SCREEN_W -> ball_x=SCREEN_W-BALL_SIZE, score_l++, -> SCORE.
- Overlap uses paddle inputs sampled on the tick cycle; all compares in 12-bit unsigned to avoid overflow.
- SCORE: ball frozen, ball_visible=0; after SCORE_FRAMES ticks -> OVER if either score==WIN_SCORE else SERVE.
- OVER: scores held; start=1 -> IDLE (scores cleared next cycle in IDLE).
- start ignored in SERVE/PLAY/SCORE. Wall and paddle bounce on same tick both applied.

Optional Feature:
SPEEDUP_EN: defined -> 3-bit hit counter; every 4 paddle hits horizontal step grows by 1, capped at SPEED+3; resets to SPEED on entry to SERVE. Undefined -> step fixed at SPEED, no counter.

Test Plan:
Reset low mid-PLAY -> outputs immediately 395/295, scores 0, state 0, frame_tick 0.
vblnk_in 0->1 held 28 cycles -> frame_tick exactly one pulse, 1 cycle after edge.
start, 60 ticks -> state 2; next tick ball_x=399, ball_y=299.
Ball moving up at ball_y=2 -> ball_y=0, next tick 4 (dir down).
Right paddle at y=290, ball approaching -> ball_x=760, dir left; paddle at y=0 -> score_l=1, state 3, ball_x=790.
score_l=8, left scores -> after 30 ticks state 4; start -> state 0, scores 0.
